// File: rtl/udp_checksum_check_if.sv
// Header field bundle plus the header and payload-stream interfaces used by udp_checksum_check.
// The package travels with the interfaces because both sides of every port need the struct.
package udp_checksum_check_pkg;

    typedef struct packed {
        logic [47:0] eth_dest_mac;
        logic [47:0] eth_src_mac;
        logic [15:0] eth_type;
        logic [3:0]  ip_version;
        logic [3:0]  ip_ihl;
        logic [5:0]  ip_dscp;
        logic [1:0]  ip_ecn;
        logic [15:0] ip_length;
        logic [15:0] ip_identification;
        logic [2:0]  ip_flags;
        logic [12:0] ip_fragment_offset;
        logic [7:0]  ip_ttl;
        logic [7:0]  ip_protocol;
        logic [15:0] ip_header_checksum;
        logic [31:0] ip_source_ip;
        logic [31:0] ip_dest_ip;
        logic [15:0] udp_source_port;
        logic [15:0] udp_dest_port;
        logic [15:0] udp_length;
        logic [15:0] udp_checksum;
    } udp_hdr_t;

endpackage

interface udp_hdr_if;
    import udp_checksum_check_pkg::*;

    logic     valid;
    logic     ready;
    udp_hdr_t hdr;

    modport master (output valid, output hdr, input ready);
    modport slave  (input valid, input hdr, output ready);
endinterface

interface udp_axis_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/udp_checksum_check.sv
// RX UDP checksum and payload-length checker: header is forwarded registered, payload streams
// through a one-beat output register, and the final beat is held until the verdict is known.
module udp_checksum_check
    import udp_checksum_check_pkg::*;
#(
    parameter bit CHECKSUM_ENABLE = 1'b1,
    parameter bit LENGTH_CHECK    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    udp_hdr_if.slave   s_udp_hdr,
    udp_axis_if.slave  s_udp_payload_axis,
    udp_hdr_if.master  m_udp_hdr,
    udp_axis_if.master m_udp_payload_axis,
    output logic       error_bad_checksum,
    output logic       error_bad_length
);

    typedef enum logic [2:0] {
        IDLE,
        PAYLOAD,
        FOLD1,
        FOLD2,
        LAST
    } state_t;

    state_t      state_q, state_d;
    udp_hdr_t    hdr_q, hdr_d;
    logic        m_hdr_valid_q, m_hdr_valid_d;
    logic [31:0] acc_q, acc_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]  hold_data_q, hold_data_d;
    logic        hold_user_q, hold_user_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;
    logic        out_user_q, out_user_d;
    logic        bad_csum_q, bad_csum_d;
    logic        bad_len_q, bad_len_d;
    logic        err_csum_q, err_csum_d;
    logic        err_len_q, err_len_d;

    logic        s_hdr_ready;
    logic        s_pay_ready;
    logic [31:0] pseudo_sum;
    logic [31:0] byte_term;
    logic [16:0] fold_sum;
    logic [15:0] sum16;
    logic        len_bad;

    // Pseudo-header + UDP header; udp_length appears twice (pseudo-header and UDP header).
    assign pseudo_sum = 32'(s_udp_hdr.hdr.ip_source_ip[31:16])
                      + 32'(s_udp_hdr.hdr.ip_source_ip[15:0])
                      + 32'(s_udp_hdr.hdr.ip_dest_ip[31:16])
                      + 32'(s_udp_hdr.hdr.ip_dest_ip[15:0])
                      + 32'h0000_0011
                      + {15'd0, s_udp_hdr.hdr.udp_length, 1'b0}
                      + 32'(s_udp_hdr.hdr.udp_source_port)
                      + 32'(s_udp_hdr.hdr.udp_dest_port)
                      + 32'(s_udp_hdr.hdr.udp_checksum);

    assign byte_term = byte_cnt_q[0] ? {24'd0, s_udp_payload_axis.tdata}
                                     : {16'd0, s_udp_payload_axis.tdata, 8'd0};
    assign fold_sum  = {1'b0, acc_q[15:0]} + {1'b0, acc_q[31:16]};
    assign sum16     = acc_q[15:0] + {15'd0, acc_q[16]};
    assign len_bad   = (hdr_q.udp_length < 16'd8) || (byte_cnt_q != hdr_q.udp_length - 16'd8);

    // NOTE: combinational next-state logic uses blocking '=' and assigns every _d a default first,
    // so no latch is inferred for paths that leave a register unchanged.
    always_comb begin
        state_d       = state_q;
        hdr_d         = hdr_q;
        m_hdr_valid_d = m_hdr_valid_q;
        acc_d         = acc_q;
        byte_cnt_d    = byte_cnt_q;
        hold_data_d   = hold_data_q;
        hold_user_d   = hold_user_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        out_last_d    = out_last_q;
        out_user_d    = out_user_q;
        bad_csum_d    = bad_csum_q;
        bad_len_d     = bad_len_q;
        err_csum_d    = 1'b0;
        err_len_d     = 1'b0;

        s_hdr_ready = (state_q == IDLE) && !m_hdr_valid_q;
        s_pay_ready = (state_q == PAYLOAD) && (!out_valid_q || m_udp_payload_axis.tready);

        if (m_hdr_valid_q && m_udp_hdr.ready) begin
            m_hdr_valid_d = 1'b0;
        end
        // The output register drains in every state, so buffered beats never stall the fold.
        if (out_valid_q && m_udp_payload_axis.tready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (s_udp_hdr.valid && s_hdr_ready) begin
                    hdr_d         = s_udp_hdr.hdr;
                    m_hdr_valid_d = 1'b1;
                    acc_d         = pseudo_sum;
                    byte_cnt_d    = 16'd0;
                    state_d       = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (s_udp_payload_axis.tvalid && s_pay_ready) begin
                    acc_d      = acc_q + byte_term;
                    byte_cnt_d = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;
                    if (s_udp_payload_axis.tlast) begin
                        hold_data_d = s_udp_payload_axis.tdata;
                        hold_user_d = s_udp_payload_axis.tuser;
                        state_d     = FOLD1;
                    end else begin
                        out_data_d  = s_udp_payload_axis.tdata;
                        out_valid_d = 1'b1;
                        out_last_d  = 1'b0;
                        out_user_d  = s_udp_payload_axis.tuser;
                    end
                end
            end
            FOLD1: begin
                acc_d   = {15'd0, fold_sum};
                state_d = FOLD2;
            end
            FOLD2: begin
                bad_csum_d = CHECKSUM_ENABLE && (hdr_q.udp_checksum != 16'h0000) && (sum16 != 16'hFFFF);
                bad_len_d  = LENGTH_CHECK && len_bad;
                state_d    = LAST;
            end
            LAST: begin
                if (out_valid_q && out_last_q && m_udp_payload_axis.tready) begin
                    err_csum_d = bad_csum_q;
                    err_len_d  = bad_len_q;
                    out_last_d = 1'b0;
                    state_d    = IDLE;
                end else if (!out_valid_q || (!out_last_q && m_udp_payload_axis.tready)) begin
                    out_data_d  = hold_data_q;
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b1;
                    out_user_d  = hold_user_q | bad_csum_q | bad_len_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state updates use non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            hdr_q         <= '0;
            m_hdr_valid_q <= 1'b0;
            acc_q         <= 32'd0;
            byte_cnt_q    <= 16'd0;
            hold_data_q   <= 8'd0;
            hold_user_q   <= 1'b0;
            out_data_q    <= 8'd0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            out_user_q    <= 1'b0;
            bad_csum_q    <= 1'b0;
            bad_len_q     <= 1'b0;
            err_csum_q    <= 1'b0;
            err_len_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            hdr_q         <= hdr_d;
            m_hdr_valid_q <= m_hdr_valid_d;
            acc_q         <= acc_d;
            byte_cnt_q    <= byte_cnt_d;
            hold_data_q   <= hold_data_d;
            hold_user_q   <= hold_user_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            out_user_q    <= out_user_d;
            bad_csum_q    <= bad_csum_d;
            bad_len_q     <= bad_len_d;
            err_csum_q    <= err_csum_d;
            err_len_q     <= err_len_d;
        end
    end

    assign s_udp_hdr.ready           = s_hdr_ready;
    assign s_udp_payload_axis.tready = s_pay_ready;

    assign m_udp_hdr.valid = m_hdr_valid_q;
    assign m_udp_hdr.hdr   = hdr_q;

    assign m_udp_payload_axis.tdata  = out_data_q;
    assign m_udp_payload_axis.tvalid = out_valid_q;
    assign m_udp_payload_axis.tlast  = out_last_q;
    assign m_udp_payload_axis.tuser  = out_user_q;

    assign error_bad_checksum = err_csum_q;
    assign error_bad_length   = err_len_q;

endmodule

// File: tb/tb_udp_checksum_check.sv
// Directed/randomized bench for udp_checksum_check; expectations come from a ones-complement
// reference computed over the pseudo-header, UDP header and payload bytes.
module tb_udp_checksum_check;
    import udp_checksum_check_pkg::*;

    localparam int WAIT_LIMIT  = 4000;
    localparam int FRAME_LIMIT = 30000;

    logic clk;
    logic rst;
    logic error_bad_checksum;
    logic error_bad_length;

    udp_hdr_if  s_hdr_if ();
    udp_hdr_if  m_hdr_if ();
    udp_axis_if s_pay_if ();
    udp_axis_if m_pay_if ();

    udp_checksum_check #(
        .CHECKSUM_ENABLE(1'b1),
        .LENGTH_CHECK   (1'b1)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .s_udp_hdr         (s_hdr_if),
        .s_udp_payload_axis(s_pay_if),
        .m_udp_hdr         (m_hdr_if),
        .m_udp_payload_axis(m_pay_if),
        .error_bad_checksum(error_bad_checksum),
        .error_bad_length  (error_bad_length)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total     = 0;
    int bad       = 0;
    bit abort     = 1'b0;
    int ready_pct = 100;

    logic [7:0] exp_data[$];
    logic       exp_user[$];
    logic       exp_csum[$];
    logic       exp_len[$];
    int         exp_size[$];
    udp_hdr_t   exp_hdr[$];

    logic [7:0] got_data[$];
    logic       got_user[$];
    int         got_size[$];
    udp_hdr_t   got_hdr[$];
    int         got_csum_frame[$];
    int         got_len_frame[$];
    int         frames_seen    = 0;
    int         beats_in_frame = 0;
    int         mid_user       = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_hdr(input string tag, input udp_hdr_t obs, input udp_hdr_t exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag, input int limit);
        total++;
        bad++;
        abort = 1'b1;
        $error("FAIL %s: no handshake within %0d cycles, required one", tag, limit);
    endtask

    // Output monitor: samples on the falling edge, away from the DUT's active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (m_pay_if.tvalid && m_pay_if.tready) begin
                    got_data.push_back(m_pay_if.tdata);
                    beats_in_frame++;
                    if (m_pay_if.tlast) begin
                        got_user.push_back(m_pay_if.tuser);
                        got_size.push_back(beats_in_frame);
                        beats_in_frame = 0;
                        frames_seen++;
                    end else if (m_pay_if.tuser) begin
                        mid_user++;
                    end
                end
                if (m_hdr_if.valid && m_hdr_if.ready) got_hdr.push_back(m_hdr_if.hdr);
                if (error_bad_checksum) got_csum_frame.push_back(frames_seen - 1);
                if (error_bad_length) got_len_frame.push_back(frames_seen - 1);
            end
        end
    end

    // Downstream ready generator.
    initial begin
        m_pay_if.tready = 1'b0;
        m_hdr_if.ready  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_pay_if.tready = int'($urandom_range(99)) < ready_pct;
            m_hdr_if.ready  = int'($urandom_range(99)) < ready_pct;
        end
    end

    // Ones-complement sum of pseudo-header, UDP header and zero-padded payload words.
    function automatic logic [15:0] ones_sum(input udp_hdr_t h, input logic [7:0] pl[$]);
        logic [31:0] s;
        logic [7:0]  lo;
        s = 32'(h.ip_source_ip[31:16]) + 32'(h.ip_source_ip[15:0]);
        s = s + 32'(h.ip_dest_ip[31:16]) + 32'(h.ip_dest_ip[15:0]);
        s = s + 32'h11 + 32'(h.udp_length);
        s = s + 32'(h.udp_source_port) + 32'(h.udp_dest_port);
        s = s + 32'(h.udp_length) + 32'(h.udp_checksum);
        for (int i = 0; i < pl.size(); i += 2) begin
            lo = (i + 1 < pl.size()) ? pl[i+1] : 8'h00;
            s  = s + 32'({pl[i], lo});
        end
        while (s[31:16] != 16'h0) s = 32'(s[15:0]) + 32'(s[31:16]);
        return s[15:0];
    endfunction

    function automatic udp_hdr_t make_hdr(input logic [31:0] sip, input logic [31:0] dip,
                                          input logic [15:0] sp, input logic [15:0] dp,
                                          input logic [15:0] len);
        logic [351:0] r;
        udp_hdr_t     h;
        for (int i = 0; i < 11; i++) r[i*32 +: 32] = $urandom();
        h                 = r[$bits(udp_hdr_t)-1:0];
        h.ip_protocol     = 8'h11;
        h.ip_source_ip    = sip;
        h.ip_dest_ip      = dip;
        h.udp_source_port = sp;
        h.udp_dest_port   = dp;
        h.udp_length      = len;
        h.udp_checksum    = 16'h0;
        return h;
    endfunction

    function automatic udp_hdr_t fix_csum(input udp_hdr_t h, input logic [7:0] pl[$]);
        udp_hdr_t    r;
        logic [15:0] c;
        r              = h;
        r.udp_checksum = 16'h0;
        c              = ~ones_sum(r, pl);
        r.udp_checksum = (c == 16'h0) ? 16'hFFFF : c;
        return r;
    endfunction

    function automatic void random_payload(output logic [7:0] pl[$], input int n);
        pl = {};
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom()));
    endfunction

    task automatic clear_scoreboard();
        exp_data.delete();  exp_user.delete(); exp_csum.delete();
        exp_len.delete();   exp_size.delete(); exp_hdr.delete();
        got_data.delete();  got_user.delete(); got_size.delete();
        got_hdr.delete();   got_csum_frame.delete(); got_len_frame.delete();
        frames_seen    = 0;
        beats_in_frame = 0;
        mid_user       = 0;
    endtask

    task automatic send_hdr(input udp_hdr_t h);
        int n;
        if (abort) return;
        s_hdr_if.hdr   = h;
        s_hdr_if.valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_hdr_if.ready && n < WAIT_LIMIT);
        if (!s_hdr_if.ready) timeout("hdr_accept", WAIT_LIMIT);
        @(posedge clk);
        #1;
        s_hdr_if.valid = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] pl[$], input int first, input int stop,
                              input bit is_final, input logic last_user, input int gap_pct);
        int n;
        for (int i = first; i < stop; i++) begin
            if (abort) return;
            while (int'($urandom_range(99)) < gap_pct) begin
                s_pay_if.tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            s_pay_if.tdata  = pl[i];
            s_pay_if.tlast  = is_final && (i == pl.size() - 1);
            s_pay_if.tuser  = is_final && (i == pl.size() - 1) && last_user;
            s_pay_if.tvalid = 1'b1;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!s_pay_if.tready && n < WAIT_LIMIT);
            if (!s_pay_if.tready) timeout("payload_accept", WAIT_LIMIT);
            @(posedge clk);
            #1;
            s_pay_if.tvalid = 1'b0;
            s_pay_if.tlast  = 1'b0;
            s_pay_if.tuser  = 1'b0;
        end
    endtask

    task automatic send_frame(input udp_hdr_t h, input logic [7:0] pl[$], input logic last_user,
                              input int gap_pct);
        logic bad_c;
        logic bad_l;
        bad_c = (h.udp_checksum != 16'h0) && (ones_sum(h, pl) != 16'hFFFF);
        bad_l = (h.udp_length < 16'd8) || (pl.size() != int'(h.udp_length) - 8);
        foreach (pl[i]) exp_data.push_back(pl[i]);
        exp_size.push_back(pl.size());
        exp_user.push_back(last_user | bad_c | bad_l);
        exp_csum.push_back(bad_c);
        exp_len.push_back(bad_l);
        exp_hdr.push_back(h);
        send_hdr(h);
        send_bytes(pl, 0, pl.size(), 1'b1, last_user, gap_pct);
    endtask

    task automatic wait_frames(input int n);
        int c;
        c = 0;
        while (frames_seen < n && c < FRAME_LIMIT && !abort) begin
            @(negedge clk);
            c++;
        end
        if (frames_seen < n && !abort) timeout("frame_out", FRAME_LIMIT);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic check_results(input string tag);
        int mm;
        int ce;
        int le;
        mm = 0;
        check({tag, "_frames"}, 64'(frames_seen), 64'(exp_size.size()));
        check({tag, "_beats"}, 64'(got_data.size()), 64'(exp_data.size()));
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            if (got_data[i] !== exp_data[i]) mm++;
        end
        check({tag, "_data_mismatches"}, 64'(mm), 64'(0));
        check({tag, "_mid_tuser"}, 64'(mid_user), 64'(0));
        for (int f = 0; f < exp_size.size(); f++) begin
            ce = 0;
            le = 0;
            foreach (got_csum_frame[k]) if (got_csum_frame[k] == f) ce++;
            foreach (got_len_frame[k]) if (got_len_frame[k] == f) le++;
            check($sformatf("%s_f%0d_csum_pulses", tag, f), 64'(ce), 64'(exp_csum[f]));
            check($sformatf("%s_f%0d_len_pulses", tag, f), 64'(le), 64'(exp_len[f]));
            if (f < got_size.size()) begin
                check($sformatf("%s_f%0d_size", tag, f), 64'(got_size[f]), 64'(exp_size[f]));
                check($sformatf("%s_f%0d_last_tuser", tag, f), 64'(got_user[f]), 64'(exp_user[f]));
            end
            if (f < got_hdr.size()) begin
                check_hdr($sformatf("%s_f%0d_hdr", tag, f), got_hdr[f], exp_hdr[f]);
            end
        end
        check({tag, "_hdr_count"}, 64'(got_hdr.size()), 64'(exp_hdr.size()));
        clear_scoreboard();
    endtask

    initial begin
        logic [7:0] pl[$];
        logic [7:0] pl2[$];
        udp_hdr_t   h;
        udp_hdr_t   h2;

        rst             = 1'b1;
        s_hdr_if.valid  = 1'b0;
        s_hdr_if.hdr    = '0;
        s_pay_if.tvalid = 1'b0;
        s_pay_if.tdata  = 8'h00;
        s_pay_if.tlast  = 1'b0;
        s_pay_if.tuser  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_m_hdr_valid", 64'(m_hdr_if.valid), 64'(0));
        check("reset_m_tvalid", 64'(m_pay_if.tvalid), 64'(0));
        check("reset_s_hdr_ready", 64'(s_hdr_if.ready), 64'(1));
        check("reset_s_tready", 64'(s_pay_if.tready), 64'(0));
        check("reset_err_csum", 64'(error_bad_checksum), 64'(0));
        check("reset_err_len", 64'(error_bad_length), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: "hello", odd length, correct checksum.
        pl = {8'h68, 8'h65, 8'h6c, 8'h6c, 8'h6f};
        h  = make_hdr(32'h0A00_0001, 32'h0A00_0002, 16'd1234, 16'd5678, 16'd13);
        h  = fix_csum(h, pl);
        send_frame(h, pl, 1'b0, 0);
        wait_frames(1);
        check_results("t1");

        // 2: same header, byte 2 corrupted.
        pl2    = pl;
        pl2[2] = 8'h6d;
        send_frame(h, pl2, 1'b0, 0);
        wait_frames(1);
        check_results("t2");

        // 3: checksum absent, corrupted payload.
        h2              = h;
        h2.udp_checksum = 16'h0;
        send_frame(h2, pl2, 1'b0, 0);
        wait_frames(1);
        check_results("t3");

        // 4: udp_length 16 with 9 payload bytes, checksum consistent with the bytes sent.
        random_payload(pl, 9);
        h = make_hdr($urandom(), $urandom(), 16'($urandom()), 16'($urandom()), 16'd16);
        h = fix_csum(h, pl);
        send_frame(h, pl, 1'b0, 0);
        wait_frames(1);
        check_results("t4");

        // 5: three back-to-back 1472-byte frames under random backpressure and source gaps.
        ready_pct = 50;
        for (int f = 0; f < 3; f++) begin
            random_payload(pl, 1472);
            h = make_hdr($urandom(), $urandom(), 16'($urandom()), 16'($urandom()), 16'd1480);
            h = fix_csum(h, pl);
            send_frame(h, pl, (f == 1), 30);
        end
        wait_frames(3);
        check_results("t5");

        // 6: reset in the middle of a payload, then a clean frame.
        ready_pct = 100;
        random_payload(pl, 40);
        h = make_hdr($urandom(), $urandom(), 16'd7, 16'd9, 16'd48);
        h = fix_csum(h, pl);
        send_hdr(h);
        send_bytes(pl, 0, 20, 1'b0, 1'b0, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6_rst_m_hdr_valid", 64'(m_hdr_if.valid), 64'(0));
        check("t6_rst_m_tvalid", 64'(m_pay_if.tvalid), 64'(0));
        check("t6_rst_s_hdr_ready", 64'(s_hdr_if.ready), 64'(1));
        check("t6_rst_s_tready", 64'(s_pay_if.tready), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_scoreboard();
        random_payload(pl, 33);
        h = make_hdr($urandom(), $urandom(), 16'($urandom()), 16'($urandom()), 16'd41);
        h = fix_csum(h, pl);
        send_frame(h, pl, 1'b0, 20);
        wait_frames(1);
        check_results("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
